// File: rtl/johnson_pkg.sv
`default_nettype none
// ============================================================================
// johnson_pkg : shared types and helpers for the Johnson sweep-bus monitor
// Rev 1.0
// ============================================================================
package johnson_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_STEPS = 2 * DEF_WIDTH;

  function automatic int num_steps(input int width);
    return 2 * width;
  endfunction

  // Filling lights bits upward; draining walks the lit bit back down.
  function automatic int led_index(input int k, input int width);
    return (k < width) ? k : (2 * width - 1 - k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_code_decode.sv
`default_nettype none
// ============================================================================
// johnson_code_decode : combinational Johnson code -> {legal, step index}
// Rev 1.0
// ============================================================================
module johnson_code_decode #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]           code_i,
  output logic                       legal_o,
  output logic [$clog2(2*WIDTH)-1:0] k_o
);

  localparam int KW = $clog2(2 * WIDTH);
  localparam logic [WIDTH-1:0] ALL = '1;

  int ones;

  always_comb begin
    ones    = 0;
    legal_o = 1'b0;
    k_o     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones += int'(code_i[i]);
    end
    // A legal code is fully determined by its popcount plus which end it fills from.
    if (code_i == ~(ALL >> ones)) begin
      legal_o = 1'b1;
      k_o     = KW'(ones);
    end else if (!code_i[WIDTH-1] && (code_i != '0) &&
                 (code_i == (ALL >> (WIDTH - ones)))) begin
      legal_o = 1'b1;
      k_o     = KW'(2 * WIDTH - ones);
    end
  end

endmodule
`default_nettype wire

// File: rtl/johnson_monitor.sv
`default_nettype none
// ============================================================================
// johnson_monitor : Johnson sweep-bus checker, decoder and sweep counter
// Optional error counter built when JOHNSON_MONITOR_ERRCNT_EN is defined.
// Rev 1.0
// ============================================================================
module johnson_monitor
  import johnson_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_STEPS = 4,
  parameter int SWEEP_W    = 16
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       ENABLE,
  input  logic                       CODE_VALID,
  input  logic [WIDTH-1:0]           CODE_IN,
  output logic [$clog2(2*WIDTH)-1:0] POS,
  output logic                       DIR,
  output logic [WIDTH-1:0]           LEDS,
  output logic                       LOCKED,
  output logic                       ERR_ILLEGAL,
  output logic                       ERR_SEQ,
  output logic [SWEEP_W-1:0]         SWEEPS,
  output logic [7:0]                 ERR_CNT
);

  localparam int STEPS = num_steps(WIDTH);
  localparam int KW    = $clog2(STEPS);
  localparam int RW    = $clog2(LOCK_STEPS + 1);

  logic          dec_legal;
  logic [KW-1:0] dec_k;

  johnson_code_decode #(.WIDTH(WIDTH)) u_decode (
    .code_i  (CODE_IN),
    .legal_o (dec_legal),
    .k_o     (dec_k)
  );

  state_t               state_q, state_d;
  logic [KW-1:0]        pos_q, pos_d;
  logic                 dir_q, dir_d;
  logic [WIDTH-1:0]     leds_q, leds_d;
  logic [RW-1:0]        run_q, run_d;
  logic                 locked_q, locked_d;
  logic                 ill_q, ill_d;
  logic                 seq_q, seq_d;
  logic [SWEEP_W-1:0]   sweeps_q, sweeps_d;

  logic          evt;
  logic [KW-1:0] next_k;
  logic          is_next;
  logic          is_same;

  assign evt     = ENABLE & CODE_VALID;
  assign next_k  = (pos_q == KW'(STEPS - 1)) ? '0 : pos_q + 1'b1;
  assign is_next = (dec_k == next_k);
  assign is_same = (dec_k == pos_q);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    leds_d   = leds_q;
    run_d    = run_q;
    ill_d    = 1'b0;
    seq_d    = 1'b0;
    sweeps_d = sweeps_q;
    if (evt) begin
      if (!dec_legal) begin
        ill_d   = 1'b1;
        state_d = ST_SEARCH;
      end else begin
        pos_d  = dec_k;
        dir_d  = (dec_k >= KW'(WIDTH));
        leds_d = WIDTH'(1) << led_index(int'(dec_k), WIDTH);
        unique case (state_q)
          ST_SEARCH: begin
            state_d = ST_TRACK;
            run_d   = '0;
          end
          ST_TRACK: begin
            if (is_next) begin
              if (run_q == RW'(LOCK_STEPS - 1)) begin
                state_d = ST_LOCKED;
                run_d   = RW'(LOCK_STEPS);
              end else begin
                run_d = run_q + 1'b1;
              end
            end else if (!is_same) begin
              run_d = '0;
            end
          end
          ST_LOCKED: begin
            if (is_next) begin
              // A sweep completes on the wrap from the last drain step back to zero.
              if ((pos_q == KW'(STEPS - 1)) && (sweeps_q != '1)) begin
                sweeps_d = sweeps_q + 1'b1;
              end
            end else if (!is_same) begin
              seq_d   = 1'b1;
              state_d = ST_TRACK;
              run_d   = '0;
            end
          end
          default: state_d = ST_SEARCH;
        endcase
      end
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= ST_SEARCH;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      leds_q   <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      ill_q    <= 1'b0;
      seq_q    <= 1'b0;
      sweeps_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      leds_q   <= leds_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      ill_q    <= ill_d;
      seq_q    <= seq_d;
      sweeps_q <= sweeps_d;
    end
  end

`ifdef JOHNSON_MONITOR_ERRCNT_EN
  logic [7:0] errcnt_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      errcnt_q <= '0;
    end else if ((ill_d | seq_d) && (errcnt_q != 8'hFF)) begin
      errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign ERR_CNT = errcnt_q;
`else
  assign ERR_CNT = 8'd0;
`endif

  assign POS         = pos_q;
  assign DIR         = dir_q;
  assign LEDS        = leds_q;
  assign LOCKED      = locked_q;
  assign ERR_ILLEGAL = ill_q;
  assign ERR_SEQ     = seq_q;
  assign SWEEPS      = sweeps_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_monitor.sv
`default_nettype none
// ============================================================================
// tb_johnson_monitor : scoreboard bench for johnson_monitor (WIDTH=8, LOCK_STEPS=4)
// Rev 1.0
// ============================================================================
module tb_johnson_monitor;
  import johnson_pkg::*;

  localparam int W   = DEF_WIDTH;
  localparam int N   = DEF_STEPS;
  localparam int LS  = 4;
  localparam int SWW = 3;

  logic             CLK = 1'b0;
  logic             RSTn = 1'b0;
  logic             ENABLE = 1'b0;
  logic             CODE_VALID = 1'b0;
  logic [W-1:0]     CODE_IN = '0;
  logic [3:0]       POS;
  logic             DIR;
  logic [W-1:0]     LEDS;
  logic             LOCKED;
  logic             ERR_ILLEGAL;
  logic             ERR_SEQ;
  logic [SWW-1:0]   SWEEPS;
  logic [7:0]       ERR_CNT;

  johnson_monitor #(.WIDTH(W), .LOCK_STEPS(LS), .SWEEP_W(SWW)) dut (
    .CLK(CLK), .RSTn(RSTn), .ENABLE(ENABLE), .CODE_VALID(CODE_VALID),
    .CODE_IN(CODE_IN), .POS(POS), .DIR(DIR), .LEDS(LEDS), .LOCKED(LOCKED),
    .ERR_ILLEGAL(ERR_ILLEGAL), .ERR_SEQ(ERR_SEQ), .SWEEPS(SWEEPS), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int pos; int dir; int leds; int locked; int ill; int seq; int sweeps; int ec;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference: the legal code table, built straight from the fill/drain definition.
  logic [W-1:0] jtab [N];
  initial begin
    logic [W-1:0] ff;
    ff = '1;
    for (int k = 0; k < N; k++) jtab[k] = (k <= W) ? (ff << (W - k)) : (ff >> (k - W));
  end

  function automatic int find_k(input logic [W-1:0] c);
    for (int k = 0; k < N; k++) if (jtab[k] == c) return k;
    return -1;
  endfunction

  // Model state: 0 searching, 1 tracking, 2 locked.
  int m_mode = 0, m_run = 0, m_pos = 0, m_locked = 0, m_sweeps = 0, m_ec = 0;
  int m_ill = 0, m_seq = 0;

  task automatic model_step(input bit rstn, input bit en, input bit vld, input logic [W-1:0] code);
    exp_t e;
    int k;
    m_ill = 0; m_seq = 0;
    if (!rstn) begin
      m_mode = 0; m_run = 0; m_pos = 0; m_sweeps = 0; m_ec = 0;
    end else if (en && vld) begin
      k = find_k(code);
      if (k < 0) begin
        m_ill = 1; m_mode = 0;
      end else begin
        if (m_mode == 0) begin
          m_mode = 1; m_run = 0;
        end else if (k == (m_pos + 1) % N) begin
          if (m_mode == 1) begin
            m_run++;
            if (m_run == LS) m_mode = 2;
          end else if (m_pos == N - 1 && m_sweeps < (1 << SWW) - 1) begin
            m_sweeps++;
          end
        end else if (k != m_pos) begin
          if (m_mode == 2) m_seq = 1;
          m_mode = 1; m_run = 0;
        end
        m_pos = k;
      end
`ifdef JOHNSON_MONITOR_ERRCNT_EN
      if ((m_ill || m_seq) && m_ec < 255) m_ec++;
`endif
    end
    m_locked = (rstn && m_mode == 2) ? 1 : 0;
    e.pos = m_pos; e.dir = (m_pos >= W);
    e.leds = (!rstn && m_pos == 0 && m_mode == 0) ? 0 : -1;
    e.locked = m_locked; e.ill = m_ill; e.seq = m_seq; e.sweeps = m_sweeps; e.ec = m_ec;
    exp_q.push_back(e);
  endtask

  // LEDS is 0 only until the first legal code after reset; track that separately.
  bit m_leds_valid = 0;

  task automatic drive(input bit rstn, input bit en, input bit vld, input logic [W-1:0] code);
    @(negedge CLK);
    RSTn = rstn; ENABLE = en; CODE_VALID = vld; CODE_IN = code;
    if (!rstn) m_leds_valid = 0;
    else if (en && vld && find_k(code) >= 0) m_leds_valid = 1;
    model_step(rstn, en, vld, code);
    exp_q[$].leds = m_leds_valid ? (1 << ((m_pos < W) ? m_pos : (N - 1 - m_pos))) : 0;
  endtask

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
  endtask

  // Monitor: outputs are registered, so every cycle presents one response.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("POS", int'(POS), e.pos);
        check("DIR", int'(DIR), e.dir);
        check("LEDS", int'(LEDS), e.leds);
        check("LOCKED", int'(LOCKED), e.locked);
        check("ERR_ILLEGAL", int'(ERR_ILLEGAL), e.ill);
        check("ERR_SEQ", int'(ERR_SEQ), e.seq);
        check("ERR_ILLEGAL_AND_SEQ", int'(ERR_ILLEGAL & ERR_SEQ), 0);
        check("SWEEPS", int'(SWEEPS), e.sweeps);
        check("ERR_CNT", int'(ERR_CNT), e.ec);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  function automatic logic [W-1:0] illegal_code();
    logic [W-1:0] c;
    do c = W'($urandom); while (find_k(c) >= 0);
    return c;
  endfunction

  initial begin
    int r;
    drive(0, 1, 1, 8'h5A);
    drive(0, 0, 0, 8'h00);
    for (int k = 0; k <= 4; k++) drive(1, 1, 1, jtab[k]);
    for (int k = 5; k <= 16; k++) drive(1, 1, 1, jtab[k % N]);
    drive(1, 1, 1, 8'hA5);
    for (int k = 12; k <= 18; k++) drive(1, 1, 1, jtab[k % N]);
    drive(1, 1, 1, 8'hF0);
    for (int k = 5; k <= 8; k++) drive(1, 1, 1, jtab[k]);
    drive(1, 1, 1, jtab[8]);
    for (int i = 0; i < 6; i++) drive(1, 0, 1, W'($urandom));
    for (int i = 0; i < 3; i++) drive(1, 1, 0, W'($urandom));
    for (int i = 0; i < 9 * N; i++) drive(1, 1, 1, jtab[(m_pos + 1) % N]);
    drive(1, 1, 1, jtab[(m_pos + 1) % N]);
    drive(0, 1, 1, jtab[(m_pos + 1) % N]);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(99);
      if (r < 70)      drive(1, 1, 1, jtab[(m_pos + 1) % N]);
      else if (r < 78) drive(1, 1, 1, jtab[m_pos]);
      else if (r < 84) drive(1, 1, 1, jtab[$urandom_range(N - 1)]);
      else if (r < 92) drive(1, 1, 1, illegal_code());
      else if (r < 96) drive(1, 0, 1, W'($urandom));
      else             drive(1, 1, 0, W'($urandom));
    end
    drive(1, 0, 0, 8'h00);
    repeat (3) @(posedge CLK);
    #2;
    check("SCOREBOARD_DRAINED", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
